// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types for the UART transmitter
//   state_t : transmitter FSM states (2-bit, IDLE=0, START=1, DATA=2, STOP=3)
//   BITS    : data bits per frame
package uart_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int BITS = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO feeding the UART serialiser
//   clk, rst        : clock, synchronous active-high reset
//   push, din       : write request and data (ignored when full)
//   pop, dout       : read request (ignored when empty), head of queue (combinational)
//   full, empty     : occupancy flags derived from count
//   count           : entries held, AW+1 bits so DEPTH is representable
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flags come from the pre-edge count, so a pop on the same edge never
  // frees room for a write that arrives while full.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with write FIFO
//   clk, rst     : clock, synchronous active-high reset
//   wr, wdata    : push one byte per asserted cycle
//   full, empty  : FIFO occupancy flags
//   count        : bytes queued, not counting the one being shifted
//   busy         : frame in progress
//   overflow     : sticky, set when a write hit a full FIFO
//   tx           : registered serial output, idle high, LSB first
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DIV   = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [7:0]    wdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          overflow,
  output logic          tx
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bitn;
  logic [7:0]     sh;
  logic [7:0]     dout;
  logic           pop;
  logic           last_tick;

  assign last_tick = (cnt == CW'(DIV - 1));
  assign busy      = (state != S_IDLE);

  // The FIFO head is consumed exactly when the FSM launches a start bit:
  // from IDLE immediately, or at the end of a stop bit for back-to-back frames.
  assign pop = !empty && ((state == S_IDLE) || (state == S_STOP && last_tick));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr),
    .din   (wdata),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bitn     <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr && full) begin
        overflow <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            sh    <= dout;
            cnt   <= '0;
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (last_tick) begin
            cnt   <= '0;
            tx    <= sh[0];
            bitn  <= '0;
            state <= S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (last_tick) begin
            cnt <= '0;
            if (bitn == 3'(BITS - 1)) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              // sh[0] is the bit on the line; sh[1] is the next one out.
              sh   <= {1'b0, sh[7:1]};
              tx   <= sh[1];
              bitn <= bitn + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (last_tick) begin
            cnt <= '0;
            if (!empty) begin
              sh    <= dout;
              tx    <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule
